// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory.
// A fetch port (read only) and a data port (read or write) compete for the
// memory; ties are broken round-robin using the owner of the previous grant.
// Every output is a flop, and next values are computed from the next state.
module mem_arbiter #(
    parameter int unsigned READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WRITE   = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic       OWN_F     = 1'b0;
    localparam logic       OWN_D     = 1'b1;
    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        grant;
    logic        grant_owner;

    logic        f_ack_q, d_ack_q, mem_wr_q, busy_q;
    logic [31:0] rdata_q, mem_addr_q, mem_wdata_q;

    // Next-state logic: arbitration in IDLE, wait counting in RD_WAIT.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant        = 1'b0;
        grant_owner  = OWN_F;
        case (state_q)
            S_IDLE: begin
                if (f_req || d_req) begin
                    grant = 1'b1;
                    if (f_req && d_req)
                        grant_owner = (last_owner_q == OWN_D) ? OWN_F : OWN_D;
                    else
                        grant_owner = d_req ? OWN_D : OWN_F;
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    if (grant_owner == OWN_D && d_wr) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_RD_WAIT: begin
                // Counter never wraps: the last wait cycle is the one at 1.
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with arbitration bookkeeping; data owns the first tie-break history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= OWN_F;
            last_owner_q <= OWN_D;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Registered outputs, derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            f_ack_q  <= (state_d == S_RESP) && (owner_d == OWN_F);
            d_ack_q  <= (state_d == S_RESP) && (owner_d == OWN_D);
            mem_wr_q <= (state_d == S_WRITE);
            busy_q   <= (state_d != S_IDLE);
            if (grant)
                mem_addr_q <= (grant_owner == OWN_D) ? d_addr : f_addr;
            if (grant && grant_owner == OWN_D && d_wr)
                mem_wdata_q <= d_wdata;
            if (state_q == S_RD_WAIT && state_d == S_RESP)
                rdata_q <= mem_rdata;
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model (grant time + fixed latency).
module tb_mem_arbiter;

    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;

    logic        f_ack, d_ack, mem_wr, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state;

    logic        a1_f_ack, a1_d_ack, a1_mem_wr, a1_busy;
    logic [31:0] a1_rdata, a1_mem_addr, a1_mem_wdata, a1_mem_rdata;
    logic [1:0]  a1_state;
    logic        a15_f_ack, a15_d_ack, a15_mem_wr, a15_busy;
    logic [31:0] a15_rdata, a15_mem_addr, a15_mem_wdata, a15_mem_rdata;
    logic [1:0]  a15_state;

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    assign mem_rdata     = memfn(mem_addr);
    assign a1_mem_rdata  = memfn(a1_mem_addr);
    assign a15_mem_rdata = memfn(a15_mem_addr);

    always #5 clk = ~clk;

    mem_arbiter #(.READ_WAIT(RW)) dut (
        .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .state(state)
    );

    mem_arbiter #(.READ_WAIT(1)) u_rw1 (
        .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_ack(a1_f_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(a1_d_ack),
        .rdata(a1_rdata), .mem_addr(a1_mem_addr), .mem_wr(a1_mem_wr), .mem_wdata(a1_mem_wdata),
        .mem_rdata(a1_mem_rdata), .busy(a1_busy), .state(a1_state)
    );

    mem_arbiter #(.READ_WAIT(15)) u_rw15 (
        .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_ack(a15_f_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(a15_d_ack),
        .rdata(a15_rdata), .mem_addr(a15_mem_addr), .mem_wr(a15_mem_wr), .mem_wdata(a15_mem_wdata),
        .mem_rdata(a15_mem_rdata), .busy(a15_busy), .state(a15_state)
    );

    // ---------------- reference model (transaction level) ----------------
    // A grant at cycle g occupies cycles g..a, where a = g+1 for a write and
    // g+RW for a read; the cycle after a is idle and may sample new requests.
    int          t = 0;
    int          g = 0;
    int          a = -100;
    bit          cv = 1'b0;
    bit          cwr = 1'b0;
    bit          cown = 1'b0;
    bit          last_own = 1'b1;
    logic [31:0] caddr = 32'h0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rdata = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cv = 1'b0; a = -100; last_own = 1'b1;
            m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
        end else begin
            t = t + 1;
            if (cv && t == a && !cwr) m_rdata = memfn(caddr);
            if (t - 1 > a && (f_req || d_req)) begin
                cown     = (f_req && d_req) ? !last_own : d_req;
                last_own = cown;
                cwr      = cown & d_wr;
                caddr    = cown ? d_addr : f_addr;
                cv       = 1'b1;
                g        = t;
                a        = cwr ? t + 1 : t + RW;
                m_addr   = caddr;
                if (cwr) m_wdata = d_wdata;
            end
        end
    end

    // ---------------- checking ----------------
    int n_asrt = 0;
    int n_fail = 0;
    logic [1:0] e_state;
    logic e_busy, e_mwr, e_fack, e_dack;

    int f_ack_cyc = -1, d_ack_cyc = -1, mw_cyc = -1, a1_cyc = -1, a15_cyc = -1;
    int d_ack_prev = -1;
    bit stream_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic check_all();
        bit in_txn;
        in_txn  = cv && t >= g && t <= a;
        e_state = !in_txn ? 2'd0 : (t == a) ? 2'd3 : (cwr ? 2'd2 : 2'd1);
        e_busy  = in_txn;
        e_mwr   = in_txn && cwr && t == g;
        e_fack  = in_txn && t == a && !cown;
        e_dack  = in_txn && t == a && cown;
        chk("state", 32'(state), 32'(e_state));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mem_wr", 32'(mem_wr), 32'(e_mwr));
        chk("f_ack", 32'(f_ack), 32'(e_fack));
        chk("d_ack", 32'(d_ack), 32'(e_dack));
        chk("rdata", rdata, m_rdata);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        if (f_ack === 1'b1) f_ack_cyc = t;
        if (mem_wr === 1'b1) mw_cyc = t;
        if (a1_f_ack === 1'b1) a1_cyc = t;
        if (a15_f_ack === 1'b1) a15_cyc = t;
        if (d_ack === 1'b1) begin
            if (stream_chk && d_ack_prev >= 0)
                chk("stream_ack_spacing", 32'(t - d_ack_prev), 32'(RW + 2));
            d_ack_prev = t;
            d_ack_cyc  = t;
        end
    endtask

    // ---------------- requester agents ----------------
    int f_todo = 0, d_todo = 0, gap = 0;
    bit rnd = 1'b0, d_stream = 1'b0;
    logic [31:0] fx_faddr = 32'h0, fx_daddr = 32'h0, fx_dwdata = 32'h0;
    logic fx_dwr = 1'b0;
    int f_raise = -1, d_raise = -1;

    task automatic load_d();
        d_req   = 1'b1;
        d_wr    = rnd ? 1'($urandom_range(0, 1)) : fx_dwr;
        d_addr  = rnd ? $urandom : fx_daddr;
        d_wdata = rnd ? $urandom : fx_dwdata;
        d_todo--;
        d_raise = t;
    endtask

    task automatic drive();
        bit fw, dw;
        fw = f_req;
        dw = d_req;
        if (f_req && e_fack) f_req = 1'b0;
        if (d_req && e_dack) begin
            d_req = 1'b0;
            if (d_stream && d_todo > 0) load_d();
        end
        if (!fw && f_todo > 0 && (gap == 0 || $urandom_range(0, gap) == 0)) begin
            f_req   = 1'b1;
            f_addr  = rnd ? $urandom : fx_faddr;
            f_todo--;
            f_raise = t;
        end
        if (!dw && d_todo > 0 && (gap == 0 || $urandom_range(0, gap) == 0)) load_d();
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (f_todo == 0 && d_todo == 0 && !f_req && !d_req && !e_busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_asrt++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL timeout_%s: observed busy after %0d cycles expected idle", tag, budget);
        end
    endtask

    // Called at a falling edge: assert reset, check at once, hold, release.
    task automatic do_reset();
        reset  = 1'b0;
        f_req  = 1'b0;
        d_req  = 1'b0;
        f_todo = 0;
        d_todo = 0;
        #1;
        check_all();
        repeat (2) step();
        reset = 1'b1;
    endtask

    initial begin
        // Power-on reset
        repeat (3) step();
        reset = 1'b1;
        step();

        // Fetch read from 0x10
        rnd = 1'b0; gap = 0;
        fx_faddr = 32'h10; f_todo = 1;
        run_until_idle("fetch_read", 20);
        chk("fetch_read_latency", 32'(f_ack_cyc - f_raise), 32'(RW + 1));
        chk("fetch_read_rdata", rdata, 32'hDEADBEEF);

        // Data write to 0x20
        fx_daddr = 32'h20; fx_dwr = 1'b1; fx_dwdata = 32'h00001234; d_todo = 1;
        run_until_idle("data_write", 20);
        chk("write_ack_latency", 32'(d_ack_cyc - d_raise), 32'd2);
        chk("write_strobe_cycle", 32'(mw_cyc - d_raise), 32'd1);
        chk("write_keeps_rdata", rdata, 32'hDEADBEEF);

        // Ties after reset: fetch wins both pairs
        do_reset();
        fx_faddr = 32'h30; fx_daddr = 32'h40; fx_dwr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            f_todo = 1; d_todo = 1;
            run_until_idle("tie", 30);
            chk("tie_fetch_latency", 32'(f_ack_cyc - f_raise), 32'(RW + 1));
            chk("tie_data_latency", 32'(d_ack_cyc - d_raise), 32'(2 * RW + 3));
        end

        // Reset in the middle of a fetch read
        f_ack_cyc = -1;
        fx_faddr = 32'h50; f_todo = 1;
        step(); step(); step();
        do_reset();
        step();
        chk("abandoned_read_no_ack", 32'(f_ack_cyc), 32'hFFFFFFFF);
        fx_faddr = 32'h60; f_todo = 1;
        run_until_idle("read_after_reset", 20);
        chk("read_after_reset_latency", 32'(f_ack_cyc - f_raise), 32'(RW + 1));
        chk("read_after_reset_rdata", rdata, memfn(32'h60));

        // READ_WAIT = 1 and 15 instances
        do_reset();
        a1_cyc = -1; a15_cyc = -1;
        fx_faddr = 32'h44; f_todo = 1;
        repeat (20) step();
        chk("rw1_ack_cycle", 32'(a1_cyc - f_raise), 32'd2);
        chk("rw15_ack_cycle", 32'(a15_cyc - f_raise), 32'd16);
        chk("rw1_rdata", a1_rdata, memfn(32'h44));
        chk("rw15_rdata", a15_rdata, memfn(32'h44));

        // Held stream of data reads
        d_stream = 1'b1; stream_chk = 1'b1; d_ack_prev = -1;
        fx_daddr = 32'h70; fx_dwr = 1'b0; d_todo = 4;
        run_until_idle("stream", 60);
        d_stream = 1'b0; stream_chk = 1'b0;

        // Random mixed traffic
        rnd = 1'b1; gap = 3;
        f_todo = 40; d_todo = 40;
        run_until_idle("random", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
